// File: rtl/adam_periph_gpio_filter_if.sv
// Pin-side bus of the GPIO input filter: pause handshake, filter config and pin levels.
// The master drives the pads and configuration; the slave is the filter.
interface adam_periph_gpio_filter_if #(
  parameter int unsigned GPIO_WIDTH  = 16,
  parameter int unsigned PRESC_WIDTH = 16,
  parameter int unsigned CNT_WIDTH   = 4
);
  logic                   pause_req;
  logic                   pause_ack;
  logic [PRESC_WIDTH-1:0] presc;
  logic [CNT_WIDTH-1:0]   filt;
  logic [GPIO_WIDTH-1:0]  en;
  logic [GPIO_WIDTH-1:0]  pad_i;
  logic [GPIO_WIDTH-1:0]  pin_o;
  logic [GPIO_WIDTH-1:0]  rise_o;
  logic [GPIO_WIDTH-1:0]  fall_o;

  modport master (
    output pause_req, presc, filt, en, pad_i,
    input  pause_ack, pin_o, rise_o, fall_o
  );

  modport slave (
    input  pause_req, presc, filt, en, pad_i,
    output pause_ack, pin_o, rise_o, fall_o
  );
endinterface

// File: rtl/adam_periph_gpio_filter.sv
// GPIO input conditioning: 2-FF synchronizer, prescaled debounce filter, edge pulses,
// all freezable through the pause handshake (the synchronizer always runs).
module adam_periph_gpio_filter #(
  parameter int unsigned GPIO_WIDTH  = 16,
  parameter int unsigned PRESC_WIDTH = 16,
  parameter int unsigned CNT_WIDTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  adam_periph_gpio_filter_if.slave    bus
);

  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [GPIO_WIDTH-1:0]                s1_q, s2_q;
  logic [GPIO_WIDTH-1:0]                pin_q, pin_d;
  logic [GPIO_WIDTH-1:0]                rise_q, rise_d;
  logic [GPIO_WIDTH-1:0]                fall_q, fall_d;
  logic [PRESC_WIDTH-1:0]               pcnt_q, pcnt_d;
  logic [GPIO_WIDTH-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                                 paused_c;
  logic                                 tick_c;

  // Pause handshake: ack is simply the registered state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.pause_req)  state_d = PAUSED;
      PAUSED:  if (!bus.pause_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign paused_c      = (state_q == PAUSED);
  assign bus.pause_ack = paused_c;

  // Prescaler, per-pin filter and edge detection
  always_comb begin
    tick_c = (pcnt_q >= bus.presc);
    pcnt_d = pcnt_q;
    pin_d  = pin_q;
    cnt_d  = cnt_q;
    rise_d = '0;
    fall_d = '0;
    if (!paused_c) begin
      pcnt_d = tick_c ? '0 : pcnt_q + PRESC_WIDTH'(1);
      for (int unsigned i = 0; i < GPIO_WIDTH; i++) begin
        if (!bus.en[i]) begin
          pin_d[i] = s2_q[i];
          cnt_d[i] = '0;
        end else if (s2_q[i] == pin_q[i]) begin
          cnt_d[i] = '0;
        end else if (tick_c) begin
          if (cnt_q[i] == bus.filt) begin
            pin_d[i] = s2_q[i];
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
          end
        end
      end
      rise_d = ~pin_q & pin_d;
      fall_d = pin_q & ~pin_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      pin_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      pcnt_q <= '0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= bus.pad_i;
      s2_q   <= s1_q;
      pin_q  <= pin_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      pcnt_q <= pcnt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.pin_o  = pin_q;
  assign bus.rise_o = rise_q;
  assign bus.fall_o = fall_q;

endmodule

// File: tb/tb_adam_periph_gpio_filter.sv
// Self-checking bench for adam_periph_gpio_filter: table of single-pin step/pulse
// vectors plus hand-written glitch-restart, pause and async-reset sequences.
module tb_adam_periph_gpio_filter;
  localparam int unsigned GW = 16;
  localparam int unsigned PW = 16;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst_n;

  adam_periph_gpio_filter_if #(.GPIO_WIDTH(GW), .PRESC_WIDTH(PW), .CNT_WIDTH(CW)) bus ();

  adam_periph_gpio_filter #(.GPIO_WIDTH(GW), .PRESC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [GW-1:0] pin;
    logic [GW-1:0] rise;
    logic [GW-1:0] fall;
    logic          ack;
  } exp_t;

  typedef struct {
    string         name;
    logic [GW-1:0] en;
    logic [PW-1:0] presc;
    logic [CW-1:0] filt;
    int            pin;
    int            pulse;     // cycles the pad is held high from k=0
    int            exp_edge;  // edge at which pin_o rises, -1 = never
    int            window;    // cycles observed
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[10];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cmp(input string tag, input string field, input logic [GW-1:0] act,
                     input logic [GW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s %s: got %h, expected %h", tag, field, act, req);
    end
  endtask

  task automatic push_exp(input logic [GW-1:0] pin, input logic [GW-1:0] rise,
                          input logic [GW-1:0] fall, input logic ack);
    exp_t e;
    e.pin = pin; e.rise = rise; e.fall = fall; e.ack = ack;
    exp_q.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s scoreboard: got empty queue, expected an entry", tag);
      return;
    end
    e = exp_q.pop_front();
    cmp(tag, "pin_o", bus.pin_o, e.pin);
    cmp(tag, "rise_o", bus.rise_o, e.rise);
    cmp(tag, "fall_o", bus.fall_o, e.fall);
    cmp(tag, "pause_ack", GW'(bus.pause_ack), GW'(e.ack));
  endtask

  task automatic do_reset(input logic [GW-1:0] en, input logic [PW-1:0] presc,
                          input logic [CW-1:0] filt);
    rst_n         = 1'b0;
    bus.pad_i     = '0;
    bus.pause_req = 1'b0;
    bus.en        = en;
    bus.presc     = presc;
    bus.filt      = filt;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [GW-1:0] m;
    string         tag;

    vecs[0] = '{"bypass",        16'h0000, 16'd0, 4'd0,  3,  100,  2,  6};
    vecs[1] = '{"deb_step",      16'hFFFF, 16'd0, 4'd3,  0,  100,  5,  9};
    vecs[2] = '{"deb_pulse3",    16'hFFFF, 16'd0, 4'd3,  0,    3, -1, 12};
    vecs[3] = '{"deb_pulse4",    16'hFFFF, 16'd0, 4'd3,  0,    4,  5,  8};
    vecs[4] = '{"presc9",        16'hFFFF, 16'd9, 4'd1,  5,  100, 19, 24};
    vecs[5] = '{"presc9_glitch", 16'hFFFF, 16'd9, 4'd1,  5,   15, -1, 40};
    vecs[6] = '{"filt0",         16'hFFFF, 16'd0, 4'd0,  7,  100,  2,  5};
    vecs[7] = '{"mixed_bypass",  16'hFDFF, 16'd0, 4'd15, 9,  100,  2,  5};
    vecs[8] = '{"filt15",        16'hFFFF, 16'd0, 4'd15, 9,  100, 17, 20};
    vecs[9] = '{"presc3_filt2",  16'hFFFF, 16'd3, 4'd2, 12,  100, 11, 14};

    // Reset state
    rst_n         = 1'b0;
    bus.pad_i     = '0;
    bus.pause_req = 1'b0;
    bus.en        = '0;
    bus.presc     = '0;
    bus.filt      = '0;
    #1;
    push_exp('0, '0, '0, 1'b0);
    check_out("reset_state");

    // Table-driven single-pin steps and pulses
    foreach (vecs[v]) begin
      do_reset(vecs[v].en, vecs[v].presc, vecs[v].filt);
      m = GW'(1) << vecs[v].pin;
      for (int k = 0; k < vecs[v].window; k++) begin
        bus.pad_i = (k < vecs[v].pulse) ? m : '0;
        push_exp((vecs[v].exp_edge >= 0 && k >= vecs[v].exp_edge) ? m : '0,
                 (k == vecs[v].exp_edge) ? m : '0, '0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        tag = $sformatf("%s_k%0d", vecs[v].name, k);
        check_out(tag);
      end
    end

    // Glitch restart: high 4, low 1, high again; accepted 5 ticks after the second rise
    do_reset(16'hFFFF, 16'd0, 4'd4);
    for (int k = 0; k < 15; k++) begin
      bus.pad_i = (k < 4 || k >= 5) ? 16'h0004 : 16'h0000;
      push_exp((k >= 11) ? 16'h0004 : '0, (k == 11) ? 16'h0004 : '0, '0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      tag = $sformatf("glitch_restart_k%0d", k);
      check_out(tag);
    end

    // Pause mid-count for 50 cycles; count resumes afterwards
    do_reset(16'hFFFF, 16'd0, 4'd4);
    for (int k = 0; k < 60; k++) begin
      bus.pad_i     = 16'h0001;
      bus.pause_req = (k >= 4 && k <= 53);
      push_exp((k >= 56) ? 16'h0001 : '0, (k == 56) ? 16'h0001 : '0, '0,
               (k >= 4 && k <= 53));
      @(posedge clk);
      @(negedge clk);
      tag = $sformatf("pause_k%0d", k);
      check_out(tag);
    end
    bus.pause_req = 1'b0;

    // Async reset between edges with all pins high
    do_reset(16'h0000, 16'd0, 4'd0);
    for (int k = 0; k < 3; k++) begin
      bus.pad_i = 16'hFFFF;
      push_exp((k >= 2) ? 16'hFFFF : '0, (k == 2) ? 16'hFFFF : '0, '0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      tag = $sformatf("areset_fill_k%0d", k);
      check_out(tag);
    end
    rst_n = 1'b0;
    #1;
    push_exp('0, '0, '0, 1'b0);
    check_out("areset_immediate");
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_exp((k >= 2) ? 16'hFFFF : '0, (k == 2) ? 16'hFFFF : '0, '0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      tag = $sformatf("areset_requal_k%0d", k);
      check_out(tag);
    end

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
